sequence_lut_reader: RTL

//  Reader side of the sequence step counter. Consumes step_counter (one count per completed

---
 rtl/sequence_lut_reader.sv | 119 +++++++++++
 1 files changed

// File: rtl/sequence_lut_reader.sv
// Sequence LUT reader: turns each step_counter increment into one in-order BRAM fetch
// and presents the fetched entry as seq_value with a one-cycle seq_valid pulse.
module sequence_lut_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  enable,
   input  logic [ADDR_WIDTH:0]   seq_length,
   input  logic [31:0]           step_counter,
   output logic                  bram_en,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic [DATA_WIDTH-1:0] seq_value,
   output logic [ADDR_WIDTH-1:0] seq_index,
   output logic                  seq_valid,
   output logic                  lag,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT1,
      S_WAIT2,
      S_CAPTURE
   } state_t;

   localparam logic [ADDR_WIDTH:0]   LEN_ONE = 1;
   localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;

   state_t                state;
   logic                  enable_q;
   logic                  prime;
   logic [31:0]           processed;
   logic [31:0]           pending;
   logic                  enable_rise;
   logic [ADDR_WIDTH:0]   len_eff;
   logic [ADDR_WIDTH-1:0] wrap_index;

   // Modulo subtraction keeps the backlog correct across a step_counter wrap.
   assign pending     = step_counter - processed;
   assign enable_rise = enable & ~enable_q;
   assign len_eff     = (seq_length == '0) ? LEN_ONE : seq_length;

   // An index left beyond a freshly shortened LUT also wraps back to 0.
   always_comb begin
      wrap_index = seq_index + IDX_ONE;
      if ({1'b0, seq_index} >= (len_eff - LEN_ONE))
         wrap_index = '0;
   end

   // bram_addr doubles as the address of the fetch in flight until it is captured.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= S_IDLE;
         enable_q  <= 1'b0;
         prime     <= 1'b0;
         processed <= '0;
         bram_en   <= 1'b0;
         bram_addr <= '0;
         seq_value <= '0;
         seq_index <= '0;
         seq_valid <= 1'b0;
         lag       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
         enable_q  <= enable;
         bram_en   <= 1'b0;
         seq_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable_rise) begin
                  prime     <= 1'b1;
                  bram_addr <= '0;
                  bram_en   <= 1'b1;
                  lag       <= 1'b0;
                  processed <= step_counter;
                  busy      <= 1'b1;
                  state     <= S_ISSUE;
               end else if (enable && (pending != 32'd0)) begin
                  prime     <= 1'b0;
                  bram_addr <= wrap_index;
                  bram_en   <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_ISSUE;
               end else if (!enable) begin
                  processed <= step_counter;
               end
            end
            S_ISSUE: state <= S_WAIT1;
            S_WAIT1: state <= S_WAIT2;
            S_WAIT2: begin
               // Read data is valid this cycle; the pulse appears while in CAPTURE.
               seq_value <= bram_dout;
               seq_index <= bram_addr;
               seq_valid <= 1'b1;
               if (!prime) begin
                  processed <= processed + 32'd1;
                  if (pending > 32'd1)
                     lag <= 1'b1;
               end
               state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
